// File: rtl/i_cache_assoc.sv
// i_cache_assoc: read-only N-way set-associative instruction cache.
// Returns a whole line per request; round-robin replacement, flush
// command plus automatic flush after reset, saturating hit/miss counters.
module i_cache_assoc #(
  parameter int DATA_WIDTH         = 32,
  parameter int TAG_WIDTH          = 14,
  parameter int INDEX_WIDTH        = 5,
  parameter int BLOCK_OFFSET_WIDTH = 2,
  parameter int NUM_WAYS           = 2,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                                                  i_Clk,
  input  logic                                                  i_Reset_n,
  input  logic                                                  i_Valid,
  input  logic [TAG_WIDTH+INDEX_WIDTH+BLOCK_OFFSET_WIDTH:0]     i_Address,
  input  logic                                                  i_Flush,
  output logic                                                  o_MEM_Valid,
  output logic [TAG_WIDTH+INDEX_WIDTH+BLOCK_OFFSET_WIDTH:0]     o_MEM_Address,
  input  logic                                                  i_MEM_Valid,
  input  logic                                                  i_MEM_Last,
  input  logic [DATA_WIDTH-1:0]                                 i_MEM_Data,
  output logic                                                  o_Ready,
  output logic                                                  o_Valid,
  output logic [DATA_WIDTH*(2**BLOCK_OFFSET_WIDTH)-1:0]         o_Data,
  output logic [CNT_WIDTH-1:0]                                  o_Hit_Count,
  output logic [CNT_WIDTH-1:0]                                  o_Miss_Count
);

  localparam int AW     = TAG_WIDTH + INDEX_WIDTH + BLOCK_OFFSET_WIDTH + 1;
  localparam int SETS   = 2 ** INDEX_WIDTH;
  localparam int WORDS  = 2 ** BLOCK_OFFSET_WIDTH;
  localparam int LINE_W = DATA_WIDTH * WORDS;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [BLOCK_OFFSET_WIDTH:0] LAST_BEAT = (BLOCK_OFFSET_WIDTH+1)'(WORDS - 1);

  typedef enum logic [1:0] {FLUSH, READY, MISS} state_t;

  state_t                   state, state_n;
  logic [INDEX_WIDTH-1:0]   flush_cnt;
  logic [BLOCK_OFFSET_WIDTH:0] beat_cnt;
  logic [TAG_WIDTH-1:0]     miss_tag;
  logic [INDEX_WIDTH-1:0]   miss_idx;
  logic [WAY_W-1:0]         miss_way;
  logic                     miss_full;
  logic                     flush_pend;
  logic [WAY_W-1:0]         rr_ptr [SETS];

  logic                     valid_mem [NUM_WAYS][SETS];
  logic [TAG_WIDTH-1:0]     tag_mem   [NUM_WAYS][SETS];
  logic [LINE_W-1:0]        data_mem  [NUM_WAYS][SETS];
  logic [DATA_WIDTH-1:0]    fill_buf  [WORDS];

  logic [TAG_WIDTH-1:0]     req_tag;
  logic [INDEX_WIDTH-1:0]   req_idx;
  logic                     hit, set_full, found;
  logic [LINE_W-1:0]        hit_line, fill_line;
  logic [WAY_W-1:0]         victim;
  logic                     hit_go, miss_go, fill_done;
  logic                     unused_addr;

  assign req_tag       = i_Address[AW-1 -: TAG_WIDTH];
  assign req_idx       = i_Address[BLOCK_OFFSET_WIDTH+1 +: INDEX_WIDTH];
  assign unused_addr   = ^i_Address[BLOCK_OFFSET_WIDTH:0];
  assign o_MEM_Address = {miss_tag, miss_idx, {(BLOCK_OFFSET_WIDTH+1){1'b0}}};

  // Tag compare across all ways and victim choice (first invalid way, else round-robin).
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    found    = 1'b0;
    victim   = '0;
    set_full = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_mem[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit      = 1'b1;
        hit_line = data_mem[w][req_idx];
      end
      if (!found && !valid_mem[w][req_idx]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
    if (!found) victim = rr_ptr[req_idx];
    set_full = !found;
  end

  // Assembled fill line with the final beat bypassed straight from memory.
  always_comb begin
    fill_line = '0;
    for (int unsigned k = 0; k + 1 < WORDS; k++)
      fill_line[k*DATA_WIDTH +: DATA_WIDTH] = fill_buf[k];
    fill_line[LINE_W-1 -: DATA_WIDTH] = i_MEM_Data;
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= FLUSH;
    else            state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n     = state;
    o_Ready     = 1'b0;
    o_Valid     = 1'b0;
    o_MEM_Valid = 1'b0;
    o_Data      = (state == READY) ? hit_line : fill_line;
    hit_go      = 1'b0;
    miss_go     = 1'b0;
    fill_done   = 1'b0;
    case (state)
      FLUSH: if (flush_cnt == '1) state_n = READY;
      READY: begin
        o_Ready = 1'b1;
        if (i_Flush) begin
          state_n = FLUSH;
        end else if (i_Valid) begin
          if (hit) begin
            o_Valid = 1'b1;
            hit_go  = 1'b1;
          end else begin
            miss_go = 1'b1;
            state_n = MISS;
          end
        end
      end
      MISS: begin
        o_MEM_Valid = 1'b1;
        if (i_MEM_Valid && i_MEM_Last) begin
          if (beat_cnt == LAST_BEAT) begin
            o_Valid   = 1'b1;
            fill_done = 1'b1;
          end
          state_n = (flush_pend || i_Flush) ? FLUSH : READY;
        end
      end
      default: state_n = FLUSH;
    endcase
  end

  // Control registers: flush walk, miss context, victim pointers, statistics.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      flush_cnt    <= '0;
      beat_cnt     <= '0;
      miss_tag     <= '0;
      miss_idx     <= '0;
      miss_way     <= '0;
      miss_full    <= 1'b0;
      flush_pend   <= 1'b0;
      o_Hit_Count  <= '0;
      o_Miss_Count <= '0;
      for (int unsigned s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else begin
      flush_cnt  <= (state == FLUSH) ? flush_cnt + INDEX_WIDTH'(1) : '0;
      flush_pend <= (state == MISS) && (flush_pend || i_Flush);
      if (miss_go) begin
        miss_tag  <= req_tag;
        miss_idx  <= req_idx;
        miss_way  <= victim;
        miss_full <= set_full;
        beat_cnt  <= '0;
      end else if ((state == MISS) && i_MEM_Valid && !beat_cnt[BLOCK_OFFSET_WIDTH]) begin
        beat_cnt <= beat_cnt + (BLOCK_OFFSET_WIDTH+1)'(1);
      end
      if (hit_go && (o_Hit_Count != '1))   o_Hit_Count  <= o_Hit_Count + CNT_WIDTH'(1);
      if (miss_go && (o_Miss_Count != '1)) o_Miss_Count <= o_Miss_Count + CNT_WIDTH'(1);
      if (fill_done && miss_full)
        rr_ptr[miss_idx] <= (NUM_WAYS > 1) ? rr_ptr[miss_idx] + WAY_W'(1) : '0;
    end
  end

  // Storage arrays: valid bits are cleared by the flush walk, so no reset is needed here.
  always_ff @(posedge i_Clk) begin
    if (state == FLUSH)
      for (int unsigned w = 0; w < NUM_WAYS; w++) valid_mem[w][flush_cnt] <= 1'b0;
    if ((state == MISS) && i_MEM_Valid && !beat_cnt[BLOCK_OFFSET_WIDTH])
      fill_buf[beat_cnt[BLOCK_OFFSET_WIDTH-1:0]] <= i_MEM_Data;
    if (fill_done) begin
      valid_mem[miss_way][miss_idx] <= 1'b1;
      tag_mem[miss_way][miss_idx]   <= miss_tag;
      data_mem[miss_way][miss_idx]  <= fill_line;
    end
  end

endmodule

// File: tb/tb_i_cache_assoc.sv
// Directed bench for i_cache_assoc at default parameters.
module tb_i_cache_assoc;

  logic         i_Clk = 1'b0;
  logic         i_Reset_n = 1'b0;
  logic         i_Valid = 1'b0;
  logic [21:0]  i_Address = '0;
  logic         i_Flush = 1'b0;
  logic         o_MEM_Valid;
  logic [21:0]  o_MEM_Address;
  logic         i_MEM_Valid = 1'b0;
  logic         i_MEM_Last = 1'b0;
  logic [31:0]  i_MEM_Data = '0;
  logic         o_Ready;
  logic         o_Valid;
  logic [127:0] o_Data;
  logic [15:0]  o_Hit_Count;
  logic [15:0]  o_Miss_Count;

  int checks = 0;
  int errors = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  localparam logic [127:0] L11    = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] L100   = 128'h00000400_00000300_00000200_00000100;
  localparam logic [127:0] L1000  = 128'h00004000_00003000_00002000_00001000;
  localparam logic [127:0] L10000 = 128'h00040000_00030000_00020000_00010000;

  i_cache_assoc #(.DATA_WIDTH(32), .TAG_WIDTH(14), .INDEX_WIDTH(5),
                  .BLOCK_OFFSET_WIDTH(2), .NUM_WAYS(2), .CNT_WIDTH(16)) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Valid(i_Valid), .i_Address(i_Address),
    .i_Flush(i_Flush), .o_MEM_Valid(o_MEM_Valid), .o_MEM_Address(o_MEM_Address),
    .i_MEM_Valid(i_MEM_Valid), .i_MEM_Last(i_MEM_Last), .i_MEM_Data(i_MEM_Data),
    .o_Ready(o_Ready), .o_Valid(o_Valid), .o_Data(o_Data),
    .o_Hit_Count(o_Hit_Count), .o_Miss_Count(o_Miss_Count));

  always #5 i_Clk = ~i_Clk;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  // One-cycle request in READY; reports the same-cycle o_Valid and o_Data.
  task automatic req(input logic [21:0] a, output logic v, output logic [127:0] d);
    i_Valid = 1'b1;
    i_Address = a;
    #1;
    v = o_Valid;
    d = o_Data;
    step();
    i_Valid = 1'b0;
  endtask

  // Serve nbeats beats of b*(k+1), Last on the final one; optional flush pulse on one beat.
  task automatic fill(input logic [31:0] b, input int nbeats, input int flush_beat,
                      output logic v, output logic [127:0] d);
    v = 1'b0;
    d = '0;
    for (int k = 0; k < nbeats; k++) begin
      i_MEM_Valid = 1'b1;
      i_MEM_Data  = b * 32'(k + 1);
      i_MEM_Last  = (k == nbeats - 1);
      i_Flush     = (k == flush_beat);
      #1;
      if (k == nbeats - 1) begin
        v = o_Valid;
        d = o_Data;
      end
      step();
    end
    i_MEM_Valid = 1'b0;
    i_MEM_Last  = 1'b0;
    i_Flush     = 1'b0;
    i_MEM_Data  = '0;
  endtask

  // Count cycles with o_Ready low, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!o_Ready && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    int n;
    step(); step();
    checks++; if (o_Ready !== 1'b0 || o_Valid !== 1'b0 || o_MEM_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got rdy=%b vld=%b mem=%b want 000", o_Ready, o_Valid, o_MEM_Valid); end
    checks++; if (o_Hit_Count !== 16'd0 || o_Miss_Count !== 16'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", o_Hit_Count, o_Miss_Count); end
    i_Valid = 1'b1;
    i_Address = 22'h000100;
    i_Reset_n = 1'b1;
    wait_ready(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL reset_flush_len got %0d want 32", n); end
    #1;
    checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL first_lookup_valid got %b want 0", o_Valid); end
    step();
    i_Valid = 1'b0;
    exp_miss = 1;
    checks++; if (o_MEM_Valid !== 1'b1 || o_MEM_Address !== 22'h000100) begin
      errors++; $display("FAIL first_miss_req got mem=%b addr=%h want 1 000100", o_MEM_Valid, o_MEM_Address); end
    checks++; if (o_Miss_Count !== 16'(exp_miss)) begin
      errors++; $display("FAIL first_miss_count got %0d want %0d", o_Miss_Count, exp_miss); end
  endtask

  task automatic test_hit_fill();
    logic v;
    logic [127:0] d;
    fill(32'h11, 4, -1, v, d);
    checks++; if (v !== 1'b1 || d !== L11) begin errors++; $display("FAIL fill_line got v=%b %h want 1 %h", v, d, L11); end
    checks++; if (o_Ready !== 1'b1) begin errors++; $display("FAIL fill_ready got %b want 1", o_Ready); end
    req(22'h000104, v, d);
    exp_hit++;
    checks++; if (v !== 1'b1 || d !== L11) begin errors++; $display("FAIL hit_same_cycle got v=%b %h want 1 %h", v, d, L11); end
    checks++; if (o_Hit_Count !== 16'd1 || o_Miss_Count !== 16'd1) begin
      errors++; $display("FAIL hit_counts got %0d/%0d want 1/1", o_Hit_Count, o_Miss_Count); end
  endtask

  task automatic test_replace();
    logic v;
    logic [127:0] d;
    req(22'h000200, v, d); exp_miss++;
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL miss_tag2 got %b want 0", v); end
    fill(32'h100, 4, -1, v, d);
    checks++; if (v !== 1'b1 || d !== L100) begin errors++; $display("FAIL fill_tag2 got v=%b %h want 1 %h", v, d, L100); end
    req(22'h000300, v, d); exp_miss++;
    fill(32'h1000, 4, -1, v, d);
    checks++; if (v !== 1'b1 || d !== L1000) begin errors++; $display("FAIL fill_tag3 got v=%b %h want 1 %h", v, d, L1000); end
    req(22'h000200, v, d); exp_hit++;
    checks++; if (v !== 1'b1 || d !== L100) begin errors++; $display("FAIL tag2_survives got v=%b %h want 1 %h", v, d, L100); end
    req(22'h000100, v, d); exp_miss++;
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL tag1_evicted got %b want 0", v); end
    fill(32'h11, 4, -1, v, d);
    req(22'h000300, v, d); exp_hit++;
    checks++; if (v !== 1'b1 || d !== L1000) begin errors++; $display("FAIL tag3_kept got v=%b %h want 1 %h", v, d, L1000); end
    req(22'h000200, v, d); exp_miss++;
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL way1_replaced got %b want 0", v); end
    fill(32'h100, 4, -1, v, d);
    checks++; if (o_Hit_Count !== 16'(exp_hit) || o_Miss_Count !== 16'(exp_miss)) begin
      errors++; $display("FAIL replace_counts got %0d/%0d want %0d/%0d", o_Hit_Count, o_Miss_Count, exp_hit, exp_miss); end
  endtask

  task automatic test_flush();
    logic v;
    logic [127:0] d;
    int n;
    i_Flush = 1'b1;
    i_Valid = 1'b1;
    i_Address = 22'h000200;
    #1;
    checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL flush_priority got %b want 0", o_Valid); end
    step();
    i_Flush = 1'b0;
    i_Valid = 1'b0;
    wait_ready(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL flush_len got %0d want 32", n); end
    checks++; if (o_Hit_Count !== 16'(exp_hit) || o_Miss_Count !== 16'(exp_miss)) begin
      errors++; $display("FAIL flush_keeps_counts got %0d/%0d want %0d/%0d", o_Hit_Count, o_Miss_Count, exp_hit, exp_miss); end
    req(22'h000200, v, d); exp_miss++;
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL after_flush_miss got %b want 0", v); end
    fill(32'h100, 4, -1, v, d);
  endtask

  task automatic test_early_last();
    logic v;
    logic [127:0] d;
    req(22'h000400, v, d); exp_miss++;
    checks++; if (o_MEM_Valid !== 1'b1 || o_MEM_Address !== 22'h000400) begin
      errors++; $display("FAIL early_req got mem=%b addr=%h want 1 000400", o_MEM_Valid, o_MEM_Address); end
    fill(32'h10000, 2, -1, v, d);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL early_no_valid got %b want 0", v); end
    checks++; if (o_Ready !== 1'b1 || o_MEM_Valid !== 1'b0) begin
      errors++; $display("FAIL early_back_ready got rdy=%b mem=%b want 1 0", o_Ready, o_MEM_Valid); end
    req(22'h000400, v, d); exp_miss++;
    checks++; if (v !== 1'b0 || o_MEM_Valid !== 1'b1) begin
      errors++; $display("FAIL early_retry got v=%b mem=%b want 0 1", v, o_MEM_Valid); end
    fill(32'h10000, 4, -1, v, d);
    checks++; if (v !== 1'b1 || d !== L10000) begin errors++; $display("FAIL retry_fill got v=%b %h want 1 %h", v, d, L10000); end
    req(22'h000400, v, d); exp_hit++;
    checks++; if (v !== 1'b1 || d !== L10000) begin errors++; $display("FAIL retry_hit got v=%b %h want 1 %h", v, d, L10000); end
    checks++; if (o_Hit_Count !== 16'(exp_hit) || o_Miss_Count !== 16'(exp_miss)) begin
      errors++; $display("FAIL early_counts got %0d/%0d want %0d/%0d", o_Hit_Count, o_Miss_Count, exp_hit, exp_miss); end
  endtask

  task automatic test_flush_mid_fill();
    logic v;
    logic [127:0] d;
    int n;
    req(22'h000500, v, d); exp_miss++;
    fill(32'h11, 4, 0, v, d);
    checks++; if (v !== 1'b1 || d !== L11) begin errors++; $display("FAIL midflush_fill got v=%b %h want 1 %h", v, d, L11); end
    wait_ready(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL midflush_len got %0d want 32", n); end
    req(22'h000500, v, d); exp_miss++;
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL midflush_invalidated got %b want 0", v); end
  endtask

  task automatic test_reset_mid_miss();
    logic v;
    logic [127:0] d;
    int n;
    checks++; if (o_MEM_Valid !== 1'b1) begin errors++; $display("FAIL pre_reset_miss got %b want 1", o_MEM_Valid); end
    i_MEM_Valid = 1'b1;
    i_MEM_Data = 32'hDEAD;
    step();
    i_MEM_Valid = 1'b0;
    i_MEM_Data = '0;
    i_Reset_n = 1'b0;
    #1;
    exp_hit = 0;
    exp_miss = 0;
    checks++; if (o_MEM_Valid !== 1'b0 || o_Ready !== 1'b0) begin
      errors++; $display("FAIL async_reset got mem=%b rdy=%b want 0 0", o_MEM_Valid, o_Ready); end
    checks++; if (o_Hit_Count !== 16'd0 || o_Miss_Count !== 16'd0) begin
      errors++; $display("FAIL reset_clears_counts got %0d/%0d want 0/0", o_Hit_Count, o_Miss_Count); end
    step();
    i_Reset_n = 1'b1;
    wait_ready(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL reflush_len got %0d want 32", n); end
    req(22'h000500, v, d); exp_miss++;
    fill(32'h100, 4, -1, v, d);
    checks++; if (v !== 1'b1 || d !== L100) begin errors++; $display("FAIL post_reset_fill got v=%b %h want 1 %h", v, d, L100); end
    checks++; if (o_Hit_Count !== 16'(exp_hit) || o_Miss_Count !== 16'(exp_miss)) begin
      errors++; $display("FAIL post_reset_counts got %0d/%0d want %0d/%0d", o_Hit_Count, o_Miss_Count, exp_hit, exp_miss); end
  endtask

  initial begin
    test_reset();
    test_hit_fill();
    test_replace();
    test_flush();
    test_early_last();
    test_flush_mid_fill();
    test_reset_mid_miss();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
